// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I multicycle control path: FSM states,
// opcodes, ALUOp and mux-select codes, and ALUControl operations.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } statetype_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus instruction fields onto an ALU operation code.
// Shared between the single-cycle and multicycle controllers.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Only R-type (op[5]=1) with funct7b5 set turns funct3=000 into a subtract.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared memory, ALU and datapath registers of the
// multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [2:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] state
);

  statetype_t state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       ir_write_raw, reg_write_raw, mem_write_raw;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Unknown opcodes fall back to FETCH straight from DECODE, skipping the instruction.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_WDATA;
    ResultSrc     = RES_ALUOUT;
    AdrSrc        = 1'b0;
    alu_op        = ALUOP_ADD;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write_raw = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
        pc_update    = 1'b1;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_A;
        alu_op  = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      ALUWB: reg_write_raw = 1'b1;
      BEQ: begin
        ALUSrcA = SRCA_A;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  // Reset masks every write enable immediately, even mid-instruction.
  assign IRWrite  = ir_write_raw & ~reset;
  assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;
  assign RegWrite = reg_write_raw & ~reset;
  assign MemWrite = mem_write_raw & ~reset;
  assign state    = state_q;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_b5       (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: an instruction-level model
// predicts the state walk and per-state controls, plus literal probe checks.
module tb_multicycle_controller;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                 S_MEMWRITE = 5, S_EXECUTER = 6, S_EXECUTEI = 7, S_ALUWB = 8,
                 S_BEQ = 9, S_JAL = 10;

  typedef struct packed {
    logic [1:0] imm;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic       adr;
    logic [2:0] alu;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       mw;
  } exp_t;

  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc;
  logic [2:0] ALUControl;
  logic       IRWrite, PCWrite, RegWrite, MemWrite;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  logic check_en = 1'b0;
  int   exp_state = 0;
  logic probe_en = 1'b0;
  logic [2:0] probe_alu;
  logic [1:0] probe_imm;
  logic probe_irw, probe_pcw, probe_rw, probe_mw;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .ALUControl(ALUControl),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level walk: which states an opcode visits, FETCH first.
  function automatic int seq_len(logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int seq_state(logic [6:0] o, int i);
    int third;
    if (i == 0) return S_FETCH;
    if (i == 1) return S_DECODE;
    case (o)
      7'b0000011: third = S_MEMADR;
      7'b0100011: third = S_MEMADR;
      7'b0110011: third = S_EXECUTER;
      7'b0010011: third = S_EXECUTEI;
      7'b1100011: third = S_BEQ;
      default:    third = S_JAL;
    endcase
    if (i == 2) return third;
    if (o == 7'b0000011) return (i == 3) ? S_MEMREAD : S_MEMWB;
    if (o == 7'b0100011) return S_MEMWRITE;
    return S_ALUWB;
  endfunction

  function automatic exp_t model(int st, logic [6:0] o, logic [2:0] f3, logic f7,
                                 logic z, logic rst);
    exp_t e;
    int aluop;
    e = '0;
    aluop = 0;
    if (o == 7'b0100011)      e.imm = 2'b01;
    else if (o == 7'b1100011) e.imm = 2'b10;
    else if (o == 7'b1101111) e.imm = 2'b11;
    case (st)
      S_FETCH:    begin e.irw = 1; e.srcb = 2'b10; e.res = 2'b10; e.pcw = 1; end
      S_DECODE:   begin e.srca = 2'b01; e.srcb = 2'b01; end
      S_MEMADR:   begin e.srca = 2'b10; e.srcb = 2'b01; end
      S_MEMREAD:  e.adr = 1;
      S_MEMWB:    begin e.res = 2'b01; e.rw = 1; end
      S_MEMWRITE: begin e.adr = 1; e.mw = 1; end
      S_EXECUTER: begin e.srca = 2'b10; aluop = 2; end
      S_EXECUTEI: begin e.srca = 2'b10; e.srcb = 2'b01; aluop = 2; end
      S_ALUWB:    e.rw = 1;
      S_BEQ:      begin e.srca = 2'b10; aluop = 1; e.pcw = z; end
      S_JAL:      begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1; end
      default: ;
    endcase
    if (aluop == 1) e.alu = 3'b001;
    else if (aluop == 2) begin
      case (f3)
        3'b000:  e.alu = (o[5] && f7) ? 3'b001 : 3'b000;
        3'b010:  e.alu = 3'b101;
        3'b110:  e.alu = 3'b011;
        3'b111:  e.alu = 3'b010;
        default: e.alu = 3'b000;
      endcase
    end
    if (rst) begin e.irw = 0; e.pcw = 0; e.rw = 0; e.mw = 0; end
    return e;
  endfunction

  task automatic cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t (state exp %0d): got %0d expected %0d",
               name, $time, exp_state, act, exp);
    end
  endtask

  // Single compare process: model check every cycle plus literal probes.
  always @(negedge clk) begin
    if (check_en) begin
      exp_t e;
      e = model(exp_state, op, funct3, funct7b5, Zero, reset);
      cmp("state", int'(state), exp_state);
      cmp("ImmSrc", int'(ImmSrc), int'(e.imm));
      cmp("ALUSrcA", int'(ALUSrcA), int'(e.srca));
      cmp("ALUSrcB", int'(ALUSrcB), int'(e.srcb));
      cmp("ResultSrc", int'(ResultSrc), int'(e.res));
      cmp("AdrSrc", int'(AdrSrc), int'(e.adr));
      cmp("ALUControl", int'(ALUControl), int'(e.alu));
      cmp("IRWrite", int'(IRWrite), int'(e.irw));
      cmp("PCWrite", int'(PCWrite), int'(e.pcw));
      cmp("RegWrite", int'(RegWrite), int'(e.rw));
      cmp("MemWrite", int'(MemWrite), int'(e.mw));
      if (probe_en) begin
        cmp("probe_ALUControl", int'(ALUControl), int'(probe_alu));
        cmp("probe_ImmSrc", int'(ImmSrc), int'(probe_imm));
        cmp("probe_IRWrite", int'(IRWrite), int'(probe_irw));
        cmp("probe_PCWrite", int'(PCWrite), int'(probe_pcw));
        cmp("probe_RegWrite", int'(RegWrite), int'(probe_rw));
        cmp("probe_MemWrite", int'(MemWrite), int'(probe_mw));
      end
    end
  end

  // Run one instruction; literal values are checked in state pstate.
  // If reset_at >= 0, reset is pulsed at that step and the walk ends there.
  task automatic applyStimulus(logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                               int pstate, logic [2:0] p_alu, logic [1:0] p_imm,
                               logic p_irw, logic p_pcw, logic p_rw, logic p_mw,
                               int reset_at);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    probe_alu = p_alu; probe_imm = p_imm; probe_irw = p_irw;
    probe_pcw = p_pcw; probe_rw = p_rw; probe_mw = p_mw;
    for (int i = 0; i < seq_len(o); i++) begin
      exp_state = seq_state(o, i);
      probe_en  = (exp_state == pstate);
      if (i == reset_at) reset = 1'b1;
      @(posedge clk);
      #1;
      probe_en = 1'b0;
      if (i == reset_at) begin
        reset = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0;
    probe_alu = 3'b0; probe_imm = 2'b0;
    probe_irw = 0; probe_pcw = 0; probe_rw = 0; probe_mw = 0;
    @(posedge clk); #1;
    exp_state = S_FETCH;
    check_en = 1'b1;
    probe_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    probe_en = 1'b0;

    // First instruction after release: FETCH with IRWrite/PCWrite high.
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, S_FETCH, 3'b000, 2'b00, 1, 1, 0, 0, -1);
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, S_MEMWB, 3'b000, 2'b00, 0, 0, 1, 0, -1);
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, S_MEMWRITE, 3'b000, 2'b01, 0, 0, 0, 1, -1);
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, S_MEMWRITE, 3'b000, 2'b01, 0, 0, 0, 0, 3);
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, S_EXECUTER, 3'b001, 2'b00, 0, 0, 0, 0, -1);
    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0, S_EXECUTER, 3'b000, 2'b00, 0, 0, 0, 0, -1);
    applyStimulus(7'b0110011, 3'b010, 1'b0, 1'b0, S_EXECUTER, 3'b101, 2'b00, 0, 0, 0, 0, -1);
    applyStimulus(7'b0110011, 3'b110, 1'b0, 1'b0, S_EXECUTER, 3'b011, 2'b00, 0, 0, 0, 0, -1);
    applyStimulus(7'b0110011, 3'b111, 1'b0, 1'b0, S_EXECUTER, 3'b010, 2'b00, 0, 0, 0, 0, -1);
    applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0, S_EXECUTEI, 3'b000, 2'b00, 0, 0, 0, 0, -1);
    applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0, S_ALUWB, 3'b000, 2'b00, 0, 0, 1, 0, -1);
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1, S_BEQ, 3'b001, 2'b10, 0, 1, 0, 0, -1);
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0, S_BEQ, 3'b001, 2'b10, 0, 0, 0, 0, -1);
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, S_JAL, 3'b000, 2'b11, 0, 1, 0, 0, -1);
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, S_ALUWB, 3'b000, 2'b11, 0, 0, 1, 0, -1);
    applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, S_DECODE, 3'b000, 2'b00, 0, 0, 0, 0, -1);
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, S_MEMREAD, 3'b000, 2'b00, 0, 0, 0, 0, -1);

    // Trailing FETCH confirms the last instruction returned to the start.
    exp_state = S_FETCH;
    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I core that replaces the single-cycle datapath behind `TOP_V0`. It sequences one shared memory, one ALU and the PC, IR, OldPC, Data, A/WriteData and ALUOut registers through a Moore FSM. Supported instructions are lw, sw, R-type, I-type ALU, beq and jal. It sits beside the datapath in the top level and drives every mux select and register enable.

## Interface
Parameters: none; all encodings come from `riscv_pkg`.

Clocking and reset: one clock, `clk`; reset `reset` is synchronous and active-high.

- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  synchronous, active-high
- `op`  in  7  instr[6:0] from IR
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `Zero`  in  1  ALU result == 0
- `ImmSrc`  out  2  00 I, 01 S, 10 B, 11 J
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 A
- `ALUSrcB`  out  2  00 WriteData, 01 ImmExt, 10 const 4
- `ResultSrc`  out  2  00 ALUOut, 01 Data, 10 ALUResult
- `AdrSrc`  out  1  0 PC, 1 Result
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite`  out  1 each  write enables
- `state`  out  4  current FSM state, for debug and verification

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Outputs not listed for a state are 0.
- Per-state outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- Transitions:
  - FETCH → DECODE.
  - DECODE: op 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL; any other op → FETCH (illegal op is skipped with no writes).
  - MEMADR: op 0000011 → MEMREAD, otherwise → MEMWRITE.
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECUTER and EXECUTEI → ALUWB → FETCH.
  - BEQ → FETCH.
  - JAL → ALUWB.
- PCWrite = PCUpdate | (Branch & Zero).
- ImmSrc is combinational on `op`: lw and I-type 00, sw 01, beq 10, jal 11; other ops 00.
- ALUControl:
  - ALUOp 00 → 000.
  - ALUOp 01 → 001.
  - ALUOp 10, by funct3: 000 → 001 if {op[5],funct7b5}==11, else 000; 010 → 101; 110 → 011; 111 → 010; other funct3 → 000.

## Timing
- Moore FSM: one state register, and outputs depend only on `state` and the current `op`/`funct3`/`funct7b5`.
- `Zero` is sampled combinationally in BEQ, in the same cycle.
- Cycles per instruction (FETCH through last state): lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- Reset:
  - A rising edge with `reset`=1 loads FETCH.
  - While `reset`=1, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0 combinationally. This also holds when reset lands mid-instruction, e.g. in MEMWRITE: MemWrite drops in the same cycle.
  - The first cycle after `reset` falls is FETCH with IRWrite=1 and PCWrite=1.
- At most one of RegWrite and MemWrite is 1 in any cycle. IRWrite is 1 only in FETCH.
- No state is held for more than one cycle; there are no stalls.

## Structure
- `riscv_pkg` holds:
  - `statetype_t` enum (4 bits, FETCH=0 in the listed order);
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - ALUOp and select-encoding localparams;
  - ALUControl codes.
- One sub-module, `alu_decoder` (ALUOp, funct3, op[5], funct7b5 → ALUControl), shared with the single-cycle core.
- The main FSM stays in `multicycle_controller`.

## Test plan
- Reset held for 2 cycles → `state`=FETCH and all four enables 0. First cycle after release: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- op=0000011 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, then FETCH on cycle 6. RegWrite=1 only in MEMWB, with ResultSrc=01; AdrSrc=1 in MEMREAD.
- op=0100011 → MemWrite=1 for exactly one cycle (MEMWRITE) with AdrSrc=1 and ImmSrc=01. Asserting reset in that cycle → MemWrite=0 the same cycle and FETCH next.
- op=0110011 in EXECUTER:
  - funct3=000, funct7b5=1 → ALUControl=001;
  - funct7b5=0 → 000;
  - funct3=010 → 101; 110 → 011; 111 → 010.
  - op=0010011, funct3=000, funct7b5=1 → 000.
- op=1100011 → BEQ on cycle 3. Zero=1 → PCWrite=1 and ImmSrc=10; Zero=0 → PCWrite=0. Back to FETCH either way.
- op=1101111 → JAL with PCWrite=1 and ImmSrc=11, then ALUWB with RegWrite=1. op=0000000 → DECODE then FETCH, with no enable asserted.
